mod_counter_chain: RTL
======================

Name: mod_counter_chain

Overview:
- Parametrised cascade of synchronous modulo counter stages, one digit per stage. Each stage has its own modulus.
- Supports up/down counting, synchronous clear, parallel load, and per-stage plus chain carry/borrow pulses.
- Serves as the general time-base/digit counter, e.g. seconds 00–59, minutes, or BCD event counters.
- The whole chain updates in one clock: stages are enabled by a combinational enable chain, with no ripple delay between stages.

Parameters:
- STAGES, 2, number of cascaded stages (1..8).
- W, 4, bits per stage value.
- MODS, {4'd6,4'd10}, packed STAGES*W vector. Field k (bits k*W+:W) is the modulus of stage k. Stage 0 is least significant. Each field must be in 2..2^W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous clear of all stages.
- load  in  1  parallel load strobe.
- load_val  in  STAGES*W  value for load, field k for stage k.
- en  in  1  count enable for stage 0.
- up  in  1  direction: 1 = up, 0 = down.
- count  out  STAGES*W  registered stage values, field k = stage k.
- stage_co  out  STAGES  registered per-stage wrap pulse.
- co  out  1  registered chain wrap pulse (carry when up, borrow when down).
- load_err  out  1  registered pulse flagging an out-of-range load field.

Behaviour:
- Reset (rst=1 at clk edge):
  - count=0, stage_co=0, co=0, load_err=0.
  - rst overrides every other input, including mid-count.
- Priority per edge: rst > clr > load > en.
- clr: count=0; stage_co, co, load_err forced 0.
- load:
  - Each field k of load_val is checked against MODS[k].
  - If field < MODS[k], the stage takes that value; otherwise the stage takes 0.
  - load_err=1 for one cycle if any field was out of range.
  - stage_co and co are forced 0 on the load cycle.
- Terminal value of stage k: MODS[k]-1 when up=1; 0 when up=0.
- Stage enable chain:
  - ena[0]=en.
  - ena[k]=ena[k-1] && stage k-1 at terminal.
  - Evaluated combinationally on current register values within the same cycle.
- Enabled stage, up=1: value MODS[k]-1 wraps to 0; otherwise value+1.
- Enabled stage, down=1 (up=0): value 0 wraps to MODS[k]-1; otherwise value-1.
- Disabled stage holds its value.
- stage_co[k]:
  - Next-cycle value = ena[k] && stage k at terminal, i.e. stage k wraps on this edge.
  - High for exactly one cycle after the wrap edge, then 0 unless it wraps again.
  - Cleared even when en=0; it does not hold.
- co = next-cycle value of ena[STAGES-1] && top stage at terminal, i.e. the whole chain wraps. Same one-cycle pulse rule.
- Latency: count and pulses are valid one clock after the causing edge. No combinational path from inputs to outputs.
- Direction change: up is sampled every edge and takes effect immediately, including on a wrap boundary.
- en=0: count holds; all pulses return to 0 next cycle.
- Out-of-range stage value: unreachable except via parameter misuse. If it occurs, an enabled increment wraps to 0 and an enabled decrement wraps to MODS[k]-1.
- Parameter legality: a MODS field outside 2..2^W-1 is a fatal elaboration error, via a generate-time check.

Decomposition:
- Package mod_chain_pkg holds:
  - MAX_STAGES=8.
  - Default MODS constant for seconds (6,10).
  - Function to extract field k from a packed vector.
  - Function to compute the terminal value from modulus and direction.
- Sub-module mod_stage holds one stage: W-bit value register, modulus input, en/up/clr/load inputs, and an at-terminal output for the enable chain. The wrap pulse is generated inside the stage.
- mod_counter_chain instantiates STAGES copies of mod_stage with a generate loop and owns co and load_err.

Test Plan:
- Count up: rst, then en=1, up=1 for 59 cycles → count=0x59. Next edge → count=0x00, and co=1 with stage_co=2'b11 for exactly one cycle.
- Count down: from reset, en=1, up=0 for one edge → count=0x59, co=1 one cycle. Next edge → count=0x58, co=0.
- Enable and hold: count=0x09, en=0 for 3 cycles → holds 0x09, stage_co=0. Then en=1 → 0x10, stage_co[0]=1 one cycle, co=0.
- Load: load=1, load_val=0x37 → count=0x37, load_err=0. Then load_val=0x3C (stage0 value 12 ≥ 10) → count=0x30, load_err=1 one cycle.
- Priority: clr=1, load=1, en=1 at count=0x42 → count=0x00. Then rst=1 with load=1, en=1 at count=0x21 → count=0x00 and all pulses 0.
- Direction flip at boundary: count=0x59 up, co pending; next edge up=0, en=1 → count=0x58. Co pulse from the earlier wrap is seen only if that wrap edge occurred.

Source files
------------

// File: rtl/mod_chain_pkg.sv
// Shared constants and helpers for the modulo counter chain.
// Field extraction and terminal-value computation are shared by top and stages.
package mod_chain_pkg;

    localparam int MAX_STAGES = 8;
    localparam int FIELD_BUS_W = 256;

    // Seconds time-base: stage 0 counts 0..9, stage 1 counts 0..5.
    localparam logic [7:0] SECONDS_MODS = {4'd6, 4'd10};

    function automatic logic [31:0] get_field(input logic [FIELD_BUS_W-1:0] vec,
                                              input int k, input int w);
        logic [FIELD_BUS_W-1:0] mask;
        mask = (FIELD_BUS_W'(1) << w) - FIELD_BUS_W'(1);
        return 32'((vec >> (k * w)) & mask);
    endfunction

    function automatic logic [31:0] terminal_val(input logic [31:0] modv, input logic up);
        return up ? (modv - 32'd1) : 32'd0;
    endfunction

endpackage

// File: rtl/mod_stage.sv
// One modulo counter digit: value register, wrap pulse and at-terminal flag
// that feeds the combinational enable chain of the next stage.
module mod_stage
    import mod_chain_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] modulus,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] count,
    output logic         at_term,
    output logic         load_bad,
    output logic         wrap
);

    logic [W-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic [W-1:0] max_val;
    logic [W-1:0] next_val;

    assign max_val  = modulus - W'(1);
    assign at_term  = (count_q == W'(terminal_val(32'(modulus), up)));
    assign load_bad = (load_val >= modulus);

    // Values at or past the top (only reachable by misuse) wrap like the terminal.
    always_comb begin
        next_val = '0;
        if (up) begin
            next_val = (count_q >= max_val) ? '0 : count_q + W'(1);
        end else begin
            next_val = (count_q == '0 || count_q > max_val) ? max_val : count_q - W'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (rst || clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_bad ? '0 : load_val;
        end else if (en) begin
            count_d = next_val;
            wrap_d  = at_term;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
        wrap_q  <= wrap_d;
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/mod_counter_chain.sv
// Cascade of modulo counter stages advanced together in a single clock by a
// combinational enable chain; owns the chain wrap pulse and load error flag.
module mod_counter_chain
    import mod_chain_pkg::*;
#(
    parameter int                  STAGES = 2,
    parameter int                  W      = 4,
    parameter logic [STAGES*W-1:0] MODS   = {4'd6, 4'd10}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                load,
    input  logic [STAGES*W-1:0] load_val,
    input  logic                en,
    input  logic                up,
    output logic [STAGES*W-1:0] count,
    output logic [STAGES-1:0]   stage_co,
    output logic                co,
    output logic                load_err
);

    logic [STAGES-1:0] ena;
    logic [STAGES-1:0] at_term;
    logic [STAGES-1:0] load_bad;
    logic              co_q, co_d;
    logic              load_err_q, load_err_d;

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $fatal(1, "mod_counter_chain: STAGES out of range");
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [W-1:0] MOD_K = W'(get_field(FIELD_BUS_W'(MODS), k, W));

        if (MOD_K < 2) begin : g_bad_mod
            $fatal(1, "mod_counter_chain: MODS field below 2");
        end

        mod_stage #(.W(W)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .load     (load),
            .load_val (load_val[k*W +: W]),
            .modulus  (MOD_K),
            .en       (ena[k]),
            .up       (up),
            .count    (count[k*W +: W]),
            .at_term  (at_term[k]),
            .load_bad (load_bad[k]),
            .wrap     (stage_co[k])
        );
    end

    // Each stage advances only when every lower stage sits at its terminal value.
    always_comb begin
        ena    = '0;
        ena[0] = en;
        for (int k = 1; k < STAGES; k++) begin
            ena[k] = ena[k-1] && at_term[k-1];
        end
    end

    always_comb begin
        co_d       = 1'b0;
        load_err_d = 1'b0;
        if (!rst && !clr) begin
            if (load) begin
                load_err_d = |load_bad;
            end else begin
                co_d = ena[STAGES-1] && at_term[STAGES-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        co_q       <= co_d;
        load_err_q <= load_err_d;
    end

    assign co       = co_q;
    assign load_err = load_err_q;

endmodule
